// File: rtl/row_clear_engine_if.sv
// Handshake and data bundle between a requester and row_clear_engine.
// The requester drives start/grid_in; the engine returns status and the compacted grid.
`timescale 1ns/1ps
interface row_clear_engine_if #(
  parameter int COLS = 10,
  parameter int ROWS = 18,
  parameter int CW   = $clog2(ROWS + 1)
);
  logic                 start;
  logic [COLS*ROWS-1:0] grid_in;
  logic                 busy;
  logic                 done;
  logic [COLS*ROWS-1:0] grid_out;
  logic [CW-1:0]        lines_cleared;

  modport master (
    output start, grid_in,
    input  busy, done, grid_out, lines_cleared
  );

  modport slave (
    input  start, grid_in,
    output busy, done, grid_out, lines_cleared
  );
endinterface

// File: rtl/row_clear_engine.sv
// Row clear engine: removes every full row from a playfield snapshot, letting the rows
// above fall down, and reports how many rows were removed. One row is examined per cycle
// (bottom to top); each removal costs one extra shift cycle plus a re-check of the same row.
`timescale 1ns/1ps
module row_clear_engine #(
  parameter int COLS = 10,
  parameter int ROWS = 18,
  parameter int CW   = $clog2(ROWS + 1)
) (
  input  logic              Clk,
  input  logic              Reset,
  row_clear_engine_if.slave bus
);

  localparam int N  = COLS * ROWS;
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

  typedef enum logic [1:0] {StIdle, StScan, StShift, StDone} state_e;

  state_e        state;
  logic [N-1:0]  work;
  logic [RW-1:0] r;
  logic [CW-1:0] count;

  logic          row_full;
  logic [N-1:0]  shifted;

  // Fullness of the row under the pointer, and the grid with rows 0..r dropped by one.
  always_comb begin
    row_full = &work[int'(r)*COLS +: COLS];
    shifted  = work;
    for (int k = 0; k < ROWS; k++) begin
      if (k == 0) begin
        shifted[0 +: COLS] = '0;
      end else if (k <= int'(r)) begin
        shifted[k*COLS +: COLS] = work[(k-1)*COLS +: COLS];
      end
    end
  end

  // Control FSM with registered status and result outputs.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state             <= StIdle;
      work              <= '0;
      r                 <= RW'(ROWS - 1);
      count             <= '0;
      bus.busy          <= 1'b0;
      bus.done          <= 1'b0;
      bus.grid_out      <= '0;
      bus.lines_cleared <= '0;
    end else begin
      bus.done <= 1'b0;
      unique case (state)
        StIdle: begin
          if (bus.start) begin
            work     <= bus.grid_in;
            r        <= RW'(ROWS - 1);
            count    <= '0;
            bus.busy <= 1'b1;
            state    <= StScan;
          end
        end
        StScan: begin
          if (row_full) begin
            state <= StShift;
          end else if (r != '0) begin
            r <= r - RW'(1);
          end else begin
            // Results are captured on entry to DONE so they are valid alongside done.
            bus.busy          <= 1'b0;
            bus.done          <= 1'b1;
            bus.grid_out      <= work;
            bus.lines_cleared <= count;
            state             <= StDone;
          end
        end
        StShift: begin
          // Pointer stays put so the row that fell into r is examined next.
          work  <= shifted;
          count <= count + CW'(1);
          state <= StScan;
        end
        StDone: begin
          state <= StIdle;
        end
        default: begin
          state <= StIdle;
        end
      endcase
    end
  end

endmodule
